// File: rtl/pid_pkg.sv
// Shared PID/PWM definitions: default fixed-point format of the PID stage
// and the state encoding of the PWM dead-time FSM.
package pid_pkg;

    localparam int PID_N = 32;
    localparam int PID_Q = 18;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_DT_LH = 2'd1,
        S_HIGH  = 2'd2,
        S_DT_HL = 2'd3
    } pwm_state_t;

    // Bits needed to hold a duty value in 0..period inclusive.
    function automatic int duty_width(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns the raw PWM level into non-overlapping high/low
// gate drives with DEAD idle cycles between every change of conducting side.
//
// state   | meaning
// S_LOW   | low side on (pwm_l = 1)
// S_DT_LH | both off, low -> high dead time
// S_HIGH  | high side on (pwm_h = 1)
// S_DT_HL | both off, high -> low dead time
module pwm_deadtime import pid_pkg::*; #(
    parameter int DEAD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pwm_h,
    output logic pwm_l
);

    localparam int TW = $clog2(DEAD + 1);

    pwm_state_t    state;
    logic [TW-1:0] dt_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_LOW;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else begin
            case (state)
                S_LOW: begin
                    pwm_h <= 1'b0;
                    if (raw) begin
                        state  <= S_DT_LH;
                        dt_cnt <= TW'(DEAD - 1);
                        pwm_l  <= 1'b0;
                    end else begin
                        pwm_l  <= 1'b1;
                    end
                end
                S_DT_LH: begin
                    if (dt_cnt != '0) begin
                        dt_cnt <= dt_cnt - TW'(1);
                    end else if (raw) begin
                        state <= S_HIGH;
                        pwm_h <= 1'b1;
                    end else begin
                        state <= S_LOW;
                        pwm_l <= 1'b1;
                    end
                end
                S_HIGH: begin
                    pwm_l <= 1'b0;
                    if (!raw) begin
                        state  <= S_DT_HL;
                        dt_cnt <= TW'(DEAD - 1);
                        pwm_h  <= 1'b0;
                    end else begin
                        pwm_h  <= 1'b1;
                    end
                end
                S_DT_HL: begin
                    if (dt_cnt != '0) begin
                        dt_cnt <= dt_cnt - TW'(1);
                    end else if (!raw) begin
                        state <= S_LOW;
                        pwm_l <= 1'b1;
                    end else begin
                        state <= S_HIGH;
                        pwm_h <= 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pid_pwm_out.sv
// PID output to PWM gate drive: clamps |data_in| to a duty in clk cycles,
// double-buffers it to the period wrap. Define PWM_DEADTIME_EN for dead time.
module pid_pwm_out import pid_pkg::*; #(
    parameter int N      = PID_N,
    parameter int Q      = PID_Q,
    parameter int PERIOD = 1000,
    parameter int DEAD   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         in_valid,
    output logic         pwm_h,
    output logic         pwm_l,
    output logic         dir,
    output logic         sat,
    output logic         period_tick
);

    localparam int DW = duty_width(PERIOD);

    if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
        $error("pid_pwm_out: PERIOD out of range 2..65535");
    end
    if (DEAD < 1 || DEAD > PERIOD / 4) begin : g_bad_dead
        $error("pid_pwm_out: DEAD out of range 1..PERIOD/4");
    end

    logic [DW-1:0] cnt;
    logic [DW-1:0] pend_duty;
    logic [DW-1:0] act_duty;
    logic          pend_dir;
    logic          pend_sat;
    logic          started;
    logic          wrap;
    logic          raw;

    logic [N:0]    ext;
    logic [N:0]    mag_abs;
    logic [63:0]   mag;
    logic [DW-1:0] duty_c;
    logic          sat_c;

    // One extra bit so the most-negative input has a representable magnitude.
    always_comb begin
        ext     = {data_in[N-1], data_in};
        mag_abs = data_in[N-1] ? (~ext + (N+1)'(1)) : ext;
        mag     = 64'(mag_abs >> Q);
        sat_c   = (mag > 64'(PERIOD));
        duty_c  = sat_c ? DW'(PERIOD) : mag[DW-1:0];
    end

    // The first edge after reset release is treated as a wrap so that the
    // sample strobe starts immediately.
    assign wrap = !started || (cnt == DW'(PERIOD - 1));
    assign raw  = (cnt < act_duty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started     <= 1'b0;
            cnt         <= '0;
            period_tick <= 1'b0;
            pend_duty   <= '0;
            pend_dir    <= 1'b0;
            pend_sat    <= 1'b0;
            act_duty    <= '0;
            dir         <= 1'b0;
            sat         <= 1'b0;
        end else begin
            started     <= 1'b1;
            cnt         <= wrap ? '0 : cnt + DW'(1);
            period_tick <= wrap;
            if (in_valid) begin
                pend_duty <= duty_c;
                pend_dir  <= data_in[N-1];
                pend_sat  <= sat_c;
            end
            if (wrap) begin
                act_duty <= pend_duty;
                dir      <= pend_dir;
                sat      <= pend_sat;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DEAD (DEAD)
    ) u_deadtime (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .pwm_h (pwm_h),
        .pwm_l (pwm_l)
    );
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            pwm_h <= raw;
            pwm_l <= ~raw;
        end
    end
`endif

endmodule
